// File: rtl/spi_dev_memrd.sv
// SPI device memory-read bridge: a DMA engine fetches 64-word bursts from a
// memory port into a 256x16 FIFO, and an SPI device port streams the FIFO
// out byte-by-byte (high byte first) after a read command byte.
// A small Wishbone register file controls the DMA and reports status.
module spi_dev_memrd #(
   parameter logic [7:0] CMD_BYTE = 8'he1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  pw_wdata,
   input  logic        pw_wcmd,
   input  logic        pw_wstb,
   output logic [7:0]  pw_rdata,
   input  logic        pw_rstb,
   input  logic        pw_end,
   output logic [31:0] mi_addr,
   output logic [6:0]  mi_len,
   output logic        mi_rw,
   output logic        mi_valid,
   input  logic        mi_ready,
   output logic [15:0] mi_wdata,
   input  logic        mi_wack,
   input  logic        mi_wlast,
   input  logic [15:0] mi_rdata,
   input  logic        mi_rstb,
   input  logic        mi_rlast,
   input  logic [31:0] wb_wdata,
   output logic [31:0] wb_rdata,
   input  logic [1:0]  wb_addr,
   input  logic        wb_we,
   input  logic        wb_cyc,
   output logic        wb_ack
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMD  = 2'd1,
      WAIT = 2'd2
   } state_t;

   // Burst is only started when the FIFO can absorb a whole 64-word burst.
   localparam logic [8:0] LEVEL_START_MAX = 9'd192;
   localparam logic [8:0] LEVEL_FULL      = 9'd256;
   localparam logic [22:0] BURST_STEP     = 23'd64;

   state_t      r_state;
   state_t      w_state_nxt;

   logic        r_dma_run;
   logic [22:0] r_dma_addr;
   logic        r_underflow;
   logic        r_wb_ack;
   logic [31:0] r_wb_rdata;

   logic [15:0] r_mem [0:255];
   logic [7:0]  r_wr_ptr;
   logic [7:0]  r_rd_ptr;
   logic [8:0]  r_level;

   logic        r_spi_active;
   logic        r_byte_lo;

   logic        w_wb_req;
   logic        w_wr_ctrl;
   logic        w_wr_addr;
   logic        w_launch;
   logic        w_push;
   logic        w_pop_req;
   logic        w_pop;
   logic        w_underflow_set;
   logic        w_cmd_hit;
   logic        w_fifo_empty;
   logic [15:0] w_head;
   logic [31:0] w_rd_mux;
   logic        w_unused;

   // Inputs with no function in a read-only bridge.
   assign w_unused = &{1'b0, mi_wack, mi_wlast, wb_wdata[31:23]};

   // A request is accepted only when no ack is in flight, giving one-cycle acks
   // separated by at least one idle cycle.
   assign w_wb_req  = wb_cyc & ~r_wb_ack;
   assign w_wr_ctrl = w_wb_req & wb_we & (wb_addr == 2'd0);
   assign w_wr_addr = w_wb_req & wb_we & (wb_addr == 2'd1);

   assign w_launch     = mi_valid & mi_ready;
   assign w_fifo_empty = (r_level == 9'd0);
   assign w_push       = (r_state == WAIT) & mi_rstb & (r_level != LEVEL_FULL);
   assign w_pop_req    = r_spi_active & pw_rstb & r_byte_lo;
   assign w_pop        = w_pop_req & ~w_fifo_empty;
   assign w_underflow_set = w_pop_req & w_fifo_empty;
   assign w_cmd_hit    = pw_wstb & pw_wcmd & (pw_wdata == CMD_BYTE);
   assign w_head       = r_mem[r_rd_ptr];

   assign mi_valid = (r_state == CMD);
   assign mi_addr  = {9'd0, r_dma_addr};
   assign mi_len   = 7'd63;
   assign mi_rw    = 1'b1;
   assign mi_wdata = 16'd0;
   assign wb_ack   = r_wb_ack;
   assign wb_rdata = r_wb_rdata;

   // DMA state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // DMA next-state: issue a burst only with room for all 64 words.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (r_dma_run && (r_level <= LEVEL_START_MAX)) begin
               w_state_nxt = CMD;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         CMD: begin
            if (mi_ready) begin
               w_state_nxt = WAIT;
            end else begin
               w_state_nxt = CMD;
            end
         end
         WAIT: begin
            if (mi_rstb && mi_rlast) begin
               w_state_nxt = IDLE;
            end else begin
               w_state_nxt = WAIT;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Control registers: run bit, sticky underflow, DMA address pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dma_run   <= 1'b0;
         r_dma_addr  <= 23'd0;
         r_underflow <= 1'b0;
      end else begin
         if (w_wr_ctrl) begin
            r_dma_run <= wb_wdata[0];
         end
         // A software load of the address beats the post-command increment.
         if (w_wr_addr) begin
            r_dma_addr <= wb_wdata[22:0];
         end else if (w_launch) begin
            r_dma_addr <= r_dma_addr + BURST_STEP;
         end
         // A fresh underflow event beats a software clear in the same cycle.
         if (w_underflow_set) begin
            r_underflow <= 1'b1;
         end else if (w_wr_ctrl && wb_wdata[1]) begin
            r_underflow <= 1'b0;
         end
      end
   end

   // Register read multiplexer.
   always_comb begin
      w_rd_mux = 32'd0;
      case (wb_addr)
         2'd0:    w_rd_mux = {7'd0, r_level, 14'd0, r_underflow, r_dma_run};
         2'd1:    w_rd_mux = {9'd0, r_dma_addr};
         default: w_rd_mux = 32'd0;
      endcase
   end

   // Wishbone ack and read data, captured on the accepting cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wb_ack   <= 1'b0;
         r_wb_rdata <= 32'd0;
      end else begin
         r_wb_ack <= w_wb_req;
         if (w_wb_req) begin
            r_wb_rdata <= w_rd_mux;
         end
      end
   end

   // FIFO storage; contents need no reset because the level gates every read.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= mi_rdata;
      end
   end

   // FIFO pointers and occupancy; push+pop together leaves the level unchanged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= 8'd0;
         r_rd_ptr <= 8'd0;
         r_level  <= 9'd0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 8'd1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 8'd1;
         end
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + 9'd1;
            2'b01:   r_level <= r_level - 9'd1;
            default: r_level <= r_level;
         endcase
      end
   end

   // SPI session tracking; chip-select release wins over a same-cycle command.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_spi_active <= 1'b0;
         r_byte_lo    <= 1'b0;
      end else begin
         if (pw_end) begin
            r_spi_active <= 1'b0;
            r_byte_lo    <= 1'b0;
         end else if (w_cmd_hit) begin
            r_spi_active <= 1'b1;
            r_byte_lo    <= 1'b0;
         end else if (r_spi_active && pw_rstb) begin
            r_byte_lo    <= ~r_byte_lo;
         end
      end
   end

   // Outgoing SPI byte: selected half of the FIFO head, zero when empty.
   always_comb begin
      pw_rdata = 8'h00;
      if (w_fifo_empty) begin
         pw_rdata = 8'h00;
      end else if (r_byte_lo) begin
         pw_rdata = w_head[7:0];
      end else begin
         pw_rdata = w_head[15:8];
      end
   end

endmodule

// File: tb/tb_spi_dev_memrd.sv
// Randomised bench for spi_dev_memrd with a queue-based reference model and
// directed literal checks for the burst, SPI, underflow and reset scenarios.
module tb_spi_dev_memrd;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [7:0]  pw_wdata;
   logic        pw_wcmd, pw_wstb, pw_rstb, pw_end;
   logic [7:0]  pw_rdata;
   logic [31:0] mi_addr;
   logic [6:0]  mi_len;
   logic        mi_rw, mi_valid, mi_ready;
   logic [15:0] mi_wdata;
   logic        mi_wack, mi_wlast;
   logic [15:0] mi_rdata;
   logic        mi_rstb, mi_rlast;
   logic [31:0] wb_wdata, wb_rdata;
   logic [1:0]  wb_addr;
   logic        wb_we, wb_cyc, wb_ack;

   spi_dev_memrd #(.CMD_BYTE(8'he1)) dut (
      .clk(clk), .rst_n(rst_n),
      .pw_wdata(pw_wdata), .pw_wcmd(pw_wcmd), .pw_wstb(pw_wstb),
      .pw_rdata(pw_rdata), .pw_rstb(pw_rstb), .pw_end(pw_end),
      .mi_addr(mi_addr), .mi_len(mi_len), .mi_rw(mi_rw),
      .mi_valid(mi_valid), .mi_ready(mi_ready),
      .mi_wdata(mi_wdata), .mi_wack(mi_wack), .mi_wlast(mi_wlast),
      .mi_rdata(mi_rdata), .mi_rstb(mi_rstb), .mi_rlast(mi_rlast),
      .wb_wdata(wb_wdata), .wb_rdata(wb_rdata), .wb_addr(wb_addr),
      .wb_we(wb_we), .wb_cyc(wb_cyc), .wb_ack(wb_ack)
   );

   int checks = 0;
   int failures = 0;

   // Reference model state
   logic [15:0] mq[$];
   bit          m_run, m_unf, m_act, m_lo, m_cmd, m_wait, m_ack;
   logic [22:0] m_addr;
   logic [31:0] m_rdata;

   // Memory responder and observation state
   int          words_left = 0;
   int          data_idx = 0;
   bit          ready_en = 1'b1;
   bit          prev_v = 1'b0;
   logic [31:0] cmd_addrs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] word_for(input int idx);
      case (idx)
         0:       return 16'h1234;
         1:       return 16'hABCD;
         default: return 16'(idx);
      endcase
   endfunction

   function automatic logic [7:0] exp_pw();
      if (mq.size() == 0) return 8'h00;
      else if (m_lo) return mq[0][7:0];
      else return mq[0][15:8];
   endfunction

   function automatic void model_reset();
      mq.delete();
      m_run = 0; m_unf = 0; m_act = 0; m_lo = 0;
      m_cmd = 0; m_wait = 0; m_ack = 0;
      m_addr = 23'd0; m_rdata = 32'd0;
   endfunction

   // One clock of the specified behaviour, using the inputs seen at the edge.
   function automatic void model_step();
      int sz = mq.size();
      bit old_run = m_run;
      bit old_act = m_act;
      bit req = wb_cyc && !m_ack;
      bit wr0 = req && wb_we && (wb_addr == 2'd0);
      bit wr1 = req && wb_we && (wb_addr == 2'd1);
      bit pop_req = m_act && pw_rstb && m_lo;
      bit push = m_wait && mi_rstb;
      bit hit = pw_wstb && pw_wcmd && (pw_wdata == 8'hE1);
      if (req) begin
         case (wb_addr)
            2'd0:    m_rdata = {7'd0, 9'(sz), 14'd0, m_unf, m_run};
            2'd1:    m_rdata = {9'd0, m_addr};
            default: m_rdata = 32'd0;
         endcase
      end
      m_ack = req;
      if (pop_req && sz > 0) void'(mq.pop_front());
      if (push) mq.push_back(mi_rdata);
      if (pop_req && sz == 0) m_unf = 1;
      else if (wr0 && wb_wdata[1]) m_unf = 0;
      if (wr0) m_run = wb_wdata[0];
      if (wr1) m_addr = wb_wdata[22:0];
      else if (m_cmd && mi_ready) m_addr = m_addr + 23'd64;
      if (m_wait) begin
         if (mi_rstb && mi_rlast) m_wait = 0;
      end else if (m_cmd) begin
         if (mi_ready) begin m_cmd = 0; m_wait = 1; end
      end else if (old_run && sz <= 192) begin
         m_cmd = 1;
      end
      if (pw_end) begin m_act = 0; m_lo = 0; end
      else if (hit) begin m_act = 1; m_lo = 0; end
      else if (old_act && pw_rstb) m_lo = !m_lo;
   endfunction

   // Per-cycle comparison of every meaningful output against the model.
   always @(negedge clk) begin
      if (rst_n) begin
         check("mi_valid", {31'd0, mi_valid}, {31'd0, m_cmd});
         if (m_cmd) begin
            check("mi_addr", mi_addr, {9'd0, m_addr});
            check("mi_len", {25'd0, mi_len}, 32'd63);
            check("mi_rw", {31'd0, mi_rw}, 32'd1);
         end
         check("pw_rdata", {24'd0, pw_rdata}, {24'd0, exp_pw()});
         check("wb_ack", {31'd0, wb_ack}, {31'd0, m_ack});
         if (m_ack) check("wb_rdata", wb_rdata, m_rdata);
         check("mi_wdata", {16'd0, mi_wdata}, 32'd0);
      end
   end

   // One clock: drive the memory responder, advance the model, clear pulses.
   task automatic tick();
      bit pre_cmd;
      mi_ready = m_cmd && ready_en && ($urandom_range(0, 2) != 0);
      if (words_left > 0 && $urandom_range(0, 3) != 0) begin
         mi_rstb = 1'b1;
         mi_rdata = word_for(data_idx);
         mi_rlast = (words_left == 1);
      end else begin
         mi_rstb = 1'b0;
         mi_rlast = 1'b0;
         mi_rdata = 16'($urandom);
      end
      @(posedge clk);
      pre_cmd = m_cmd;
      model_step();
      if (mi_ready && pre_cmd) words_left = 64;
      if (mi_rstb) begin words_left--; data_idx++; end
      #1;
      pw_wstb = 1'b0; pw_wcmd = 1'b0; pw_rstb = 1'b0; pw_end = 1'b0;
      if (mi_valid && !prev_v) cmd_addrs.push_back(mi_addr);
      prev_v = mi_valid;
   endtask

   task automatic wb_xfer(input bit we, input logic [1:0] a, input logic [31:0] d,
                          output logic [31:0] rd);
      int n = 0;
      wb_cyc = 1'b1; wb_we = we; wb_addr = a; wb_wdata = d;
      tick(); n++;
      while (!m_ack && n < 3) begin tick(); n++; end
      rd = wb_rdata;
      wb_cyc = 1'b0; wb_we = 1'b0;
   endtask

   task automatic spi_cmd(input logic [7:0] b, input bit is_cmd);
      pw_wdata = b; pw_wcmd = is_cmd; pw_wstb = 1'b1;
      tick();
   endtask

   logic [31:0] rd;
   int i;

   initial begin
      rst_n = 1'b0;
      pw_wdata = 8'd0; pw_wcmd = 0; pw_wstb = 0; pw_rstb = 0; pw_end = 0;
      mi_ready = 0; mi_wack = 0; mi_wlast = 0; mi_rdata = 16'd0; mi_rstb = 0; mi_rlast = 0;
      wb_wdata = 32'd0; wb_addr = 2'd0; wb_we = 0; wb_cyc = 0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("rst_pw_rdata", {24'd0, pw_rdata}, 32'd0);
      check("rst_mi_valid", {31'd0, mi_valid}, 32'd0);
      check("rst_wb_ack", {31'd0, wb_ack}, 32'd0);
      check("rst_wb_rdata", wb_rdata, 32'd0);
      rst_n = 1'b1;
      wb_xfer(0, 2'd0, 32'd0, rd); check("rst_reg0", rd, 32'd0);
      wb_xfer(0, 2'd1, 32'd0, rd); check("rst_reg1", rd, 32'd0);

      // Four bursts fill the FIFO, then the fifth is withheld.
      wb_xfer(1, 2'd1, 32'h0000_0100, rd);
      wb_xfer(0, 2'd1, 32'd0, rd); check("reg1_base", rd, 32'h0000_0100);
      wb_xfer(0, 2'd3, 32'd0, rd); check("reg3_zero", rd, 32'd0);
      cmd_addrs.delete();
      wb_xfer(1, 2'd0, 32'h1, rd);
      i = 0;
      while (i < 3000 && !(mq.size() == 256 && !m_cmd && !m_wait)) begin tick(); i++; end
      check("fill_timeout", {31'd0, (mq.size() == 256)}, 32'd1);
      repeat (60) tick();
      check("fill_cmd_count", cmd_addrs.size(), 32'd4);
      if (cmd_addrs.size() >= 4) begin
         check("cmd0_addr", cmd_addrs[0], 32'h0000_0100);
         check("cmd1_addr", cmd_addrs[1], 32'h0000_0140);
         check("cmd3_addr", cmd_addrs[3], 32'h0000_01C0);
      end
      wb_xfer(0, 2'd0, 32'd0, rd); check("reg0_full", rd, 32'h0100_0001);
      wb_xfer(0, 2'd1, 32'd0, rd); check("reg1_after4", rd, 32'h0000_0200);

      // SPI read command and first four bytes.
      spi_cmd(8'hE1, 1'b1); check("spi_b0", {24'd0, pw_rdata}, 32'h12);
      pw_rstb = 1; tick(); check("spi_b1", {24'd0, pw_rdata}, 32'h34);
      pw_rstb = 1; tick(); check("spi_b2", {24'd0, pw_rdata}, 32'hAB);
      pw_rstb = 1; tick(); check("spi_b3", {24'd0, pw_rdata}, 32'hCD);
      pw_rstb = 1; tick();
      wb_xfer(0, 2'd0, 32'd0, rd); check("reg0_after_spi", rd, 32'h00FE_0001);

      // Randomised mix of SPI, register and memory traffic.
      for (int k = 0; k < 3000; k++) begin
         int r = $urandom_range(0, 99);
         if (r < 8) begin
            logic [1:0] a = 2'($urandom_range(0, 3));
            bit we = ($urandom_range(0, 1) == 1);
            logic [31:0] d = $urandom;
            if (a == 2'd0) d = {31'd0, ($urandom_range(0, 4) != 0)};
            wb_xfer(we, a, d, rd);
         end else begin
            if (!m_act && r < 14) begin
               if (r < 12) spi_cmd(8'hE1, 1'b1);
               else spi_cmd(8'hE1 ^ 8'($urandom_range(1, 255)), ($urandom_range(0, 1) == 1));
            end else begin
               if (m_act && r < 16) pw_end = 1;
               else if (r < 75) pw_rstb = 1;
               tick();
            end
         end
      end

      // Clearing run mid-burst: burst completes, address advances once (with wrap).
      wb_xfer(1, 2'd0, 32'd0, rd);
      i = 0;
      while (i < 1000 && (m_cmd || m_wait)) begin tick(); i++; end
      check("idle_timeout", {30'd0, m_cmd, m_wait}, 32'd0);
      wb_xfer(1, 2'd1, 32'h007F_FFC0, rd);
      cmd_addrs.delete();
      wb_xfer(1, 2'd0, 32'h1, rd);
      i = 0;
      while (i < 2000 && !m_wait) begin
         if (!m_act) spi_cmd(8'hE1, 1'b1);
         else begin pw_rstb = 1; tick(); end
         i++;
      end
      check("wait_timeout", {31'd0, m_wait}, 32'd1);
      wb_xfer(1, 2'd0, 32'd0, rd);
      i = 0;
      while (i < 500 && m_wait) begin tick(); i++; end
      repeat (100) tick();
      check("stop_cmd_count", cmd_addrs.size(), 32'd1);
      if (cmd_addrs.size() >= 1) check("wrap_cmd_addr", cmd_addrs[0], 32'h007F_FFC0);
      wb_xfer(0, 2'd1, 32'd0, rd); check("reg1_wrapped", rd, 32'd0);
      wb_xfer(0, 2'd0, 32'd0, rd); check("reg0_run_off", {31'd0, rd[0]}, 32'd0);

      // Underflow: drain, read past empty, then clear.
      pw_end = 1; tick();
      wb_xfer(1, 2'd0, 32'h2, rd);
      spi_cmd(8'hE1, 1'b1);
      i = 0;
      while (i < 1200 && mq.size() > 0) begin pw_rstb = 1; tick(); i++; end
      check("drain_timeout", mq.size(), 32'd0);
      pw_rstb = 1; tick(); check("empty_pw_rdata", {24'd0, pw_rdata}, 32'd0);
      pw_rstb = 1; tick();
      wb_xfer(0, 2'd0, 32'd0, rd); check("reg0_underflow", rd, 32'h0000_0002);
      wb_xfer(1, 2'd0, 32'h2, rd);
      wb_xfer(0, 2'd0, 32'd0, rd); check("reg0_unf_clear", rd, 32'd0);

      // Reset while a command is outstanding, then stray read data.
      pw_end = 1; tick();
      ready_en = 0;
      wb_xfer(1, 2'd0, 32'h1, rd);
      i = 0;
      while (i < 20 && !m_cmd) begin tick(); i++; end
      check("cmd_timeout", {31'd0, mi_valid}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_cmd_mi_valid", {31'd0, mi_valid}, 32'd0);
      check("rst_cmd_wb_ack", {31'd0, wb_ack}, 32'd0);
      check("rst_cmd_pw_rdata", {24'd0, pw_rdata}, 32'd0);
      model_reset();
      ready_en = 1;
      words_left = 5;
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      prev_v = 0;
      repeat (20) tick();
      wb_xfer(0, 2'd0, 32'd0, rd); check("post_rst_reg0", rd, 32'd0);
      wb_xfer(0, 2'd1, 32'd0, rd); check("post_rst_reg1", rd, 32'd0);
      repeat (5) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/spi_dev_memrd.md
SPI_DEV_MEMRD -- requirements
Module: spi_dev_memrd

Interface
REQ-001 SHALL have parameter CMD_BYTE, default 8'he1: SPI command byte that opens a memory-read data phase.
REQ-002 SHALL have ports clk in 1 (single clock), rst_n in 1 (reset, asynchronous, active-low).
REQ-003 SHALL have ports pw_wdata in 8 (SPI byte received), pw_wcmd in 1 (byte is command), pw_wstb in 1 (received-byte strobe), pw_rdata out 8 (byte to shift out), pw_rstb in 1 (pw_rdata consumed), pw_end in 1 (chip-select release).
REQ-004 SHALL have ports mi_addr out 32, mi_len out 7, mi_rw out 1, mi_valid out 1, mi_ready in 1 (command handshake).
REQ-005 SHALL have ports mi_wdata out 16 (unused, tied 0), mi_wack in 1 (unused), mi_wlast in 1 (unused), mi_rdata in 16, mi_rstb in 1, mi_rlast in 1 (read data stream).
REQ-006 SHALL have ports wb_wdata in 32, wb_rdata out 32, wb_addr in 2, wb_we in 1, wb_cyc in 1, wb_ack out 1.

Function
REQ-007 wb_ack SHALL assert one cycle after wb_cyc and last one cycle; a new ack SHALL not start until the next cycle.
REQ-008 A write to addr 0 SHALL set dma_run = wb_wdata[0]; wb_wdata[1]=1 SHALL clear the underflow flag.
REQ-009 A write to addr 1 SHALL load dma_addr[22:0] = wb_wdata[22:0].
REQ-010 Reads SHALL return: addr 0 = {7'b0, fifo_level[8:0], 14'b0, underflow, dma_run}; addr 1 = {9'b0, dma_addr}; addr 2/3 = 0; wb_rdata SHALL be valid while wb_ack is high.
REQ-011 Buffer SHALL be a 256 x 16 synchronous FIFO; fifo_level (9 bits, 0..256) SHALL track occupancy, with simultaneous push and pop leaving it unchanged.
REQ-012 DMA FSM SHALL use states IDLE, CMD, WAIT.
REQ-013 IDLE->CMD SHALL occur when dma_run=1 and fifo_level <= 192.
REQ-014 In CMD mi_valid SHALL be 1; CMD->WAIT SHALL occur on mi_ready.
REQ-015 In WAIT, each mi_rstb SHALL push mi_rdata; WAIT->IDLE SHALL occur on mi_rstb & mi_rlast.
REQ-016 mi_len SHALL be 7'd63 (64-word burst), mi_rw SHALL be 1, mi_addr SHALL be {9'b0, dma_addr}.
REQ-017 dma_addr SHALL increment by 64 on mi_valid & mi_ready, wrapping modulo 2^23; a simultaneous addr-1 write SHALL take priority.
REQ-018 Clearing dma_run mid-burst SHALL let the current burst complete; no new burst SHALL issue.
REQ-019 spi_active SHALL set on the cycle after pw_wstb & pw_wcmd & (pw_wdata == CMD_BYTE) and clear on pw_end; pw_end in the same cycle as a command SHALL win.
REQ-020 While spi_active, the byte order SHALL be high byte then low byte of the FIFO head word; byte_sel SHALL toggle on pw_rstb and reset to high on entry or exit of spi_active.
REQ-021 pw_rstb while byte_sel = low SHALL pop the FIFO; a pop when empty SHALL be suppressed and SHALL set the sticky underflow flag.
REQ-022 pw_rdata SHALL be the selected byte when the FIFO is non-empty, else 8'h00; pw_rstb outside spi_active SHALL be ignored.
REQ-023 The design SHALL never push into a full FIFO; REQ-013 guarantees room for a full burst.

Reset
REQ-024 Asserting rst_n low SHALL immediately force: FSM=IDLE, mi_valid=0, dma_run=0, dma_addr=0, fifo_level=0 (FIFO empty), spi_active=0, byte_sel=high, underflow=0, wb_ack=0, pw_rdata=8'h00, wb_rdata=0.
REQ-025 Reset asserted mid-burst SHALL abandon the burst; mi_rstb arriving after reset release while in IDLE SHALL be ignored.

Verification
REQ-026 Write base 0x000100, run=1; memory returns 64 words 0x0000..0x003F -> one command at mi_addr 0x100 with mi_len 63; fifo_level=64; no second command while level > 192 is false... second command at 0x140 issues after first completes.
REQ-027 Fill FIFO to 256 (4 bursts) -> no fifo_level > 256; 5th command withheld until SPI drains level to 192.
REQ-028 SPI: command 0xE1, then 4 pw_rstb with head words 0x1234, 0xABCD -> pw_rdata sequence 0x12, 0x34, 0xAB, 0xCD; fifo_level decrements by 2.
REQ-029 SPI read with empty FIFO -> pw_rdata=0x00, underflow=1 on addr-0 read; wb write bit1 -> underflow=0.
REQ-030 Clear run during WAIT -> burst finishes on mi_rlast, FSM stays IDLE, dma_addr advanced by exactly 64.
REQ-031 Pull rst_n low in CMD state -> mi_valid=0 same cycle, all REQ-024 values hold after release.
